bias_relu_pack: RTL and testbench
=================================

BIAS_RELU_PACK -- requirements
Module: bias_relu_pack

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 16, giving the signed sample width (the codebase data_len).
REQ-002 The block SHALL have parameter CH, default 32, giving the output channels per packed vector; legal values 2..64.
REQ-003 The block SHALL have parameter CW, default $clog2(CH), giving the channel index width.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 clear  in  1  synchronous abandon of the partially filled vector.
REQ-007 in_valid  in  1  in_data carries one dot-product result from the upstream 288-element inner-product stage.
REQ-008 in_data  in  DATA_LEN  signed dot-product result for channel ch_idx.
REQ-009 in_ready  out  1  block accepts in_data this cycle.
REQ-010 bias  in  CH*DATA_LEN  signed per-channel bias; channel k at [k*DATA_LEN +: DATA_LEN]; quasi-static.
REQ-011 shift  in  4  arithmetic right-shift amount 0..15; quasi-static.
REQ-012 ch_idx  out  CW  channel slot the next accepted sample fills.
REQ-013 out_valid  out  1  out_data holds a complete CH-channel vector.
REQ-014 out_ready  in  1  downstream consumes the vector.
REQ-015 out_data  out  CH*DATA_LEN  packed activations; channel k at [k*DATA_LEN +: DATA_LEN].

Function
REQ-016 The block SHALL implement two states: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1); in_ready and out_valid SHALL be registered.
REQ-017 The block SHALL accept a sample when in_valid && in_ready is high at a rising edge.
REQ-018 Per accepted sample, the block SHALL compute s = in_data + bias[ch_idx] at DATA_LEN+1 bits signed, then t = s >>> shift with sign extension.
REQ-019 The block SHALL apply ReLU and saturation: t<0 -> 0; t > 2^(DATA_LEN-1)-1 -> 2^(DATA_LEN-1)-1; otherwise t.
REQ-020 The block SHALL write the result into out_data slot ch_idx on the accepting edge and increment ch_idx.
REQ-021 On acceptance with ch_idx==CH-1, ch_idx SHALL wrap to 0 and the state SHALL go FILL->HOLD; out_valid SHALL be 1 in the next cycle (latency 1 cycle from the last accept).
REQ-022 In HOLD, out_data SHALL stay stable and in_valid SHALL be ignored.
REQ-023 In HOLD with out_ready=1, the state SHALL return to FILL on that edge; in_ready SHALL be 1 the following cycle; the next vector is never accepted in the same cycle as the handoff.
REQ-024 out_ready SHALL be ignored in FILL.
REQ-025 Slots not yet rewritten in a new vector SHALL retain old values; only out_valid qualifies out_data.
REQ-026 clear=1 SHALL set ch_idx=0 and state=FILL, dropping any HOLD vector without handshake; clear SHALL win over a simultaneous in_valid, out_ready, or the final-channel accept.
REQ-027 Changing bias or shift mid-vector SHALL affect only samples accepted after the change.

Reset
REQ-028 While rst=1 at an edge: state=FILL, ch_idx=0, out_valid=0, in_ready=1, out_data=0; rst SHALL override clear and all handshakes, including mid-vector and in HOLD.
REQ-029 The first cycle after rst deasserts SHALL be able to accept a sample.

Verification (DATA_LEN=16, CH=4 unless stated)
REQ-030 Bench: bias={0,0,0,0}, shift=0, in 10,20,30,40 back-to-back -> out_valid 1 cycle after 4th accept; out_data slots {10,20,30,40}; in_ready=0 until out_ready.
REQ-031 Bench: bias[1]=-50, shift=2, in_data ch0=100, ch1=20, ch2=-4, ch3=32767 with bias[3]=32767 -> slots {25,0,0,16383}; ch2 shows ReLU, ch3 shows the 17-bit sum surviving the shift.
REQ-032 Bench: shift=0, in_data=32000, bias=32000 -> slot 32767 (saturation); in_data=-32768, bias=-32768 -> 0.
REQ-033 Bench: full vector, hold out_ready=0 for 10 cycles with in_valid=1 -> out_data unchanged, no sample consumed; then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-034 Bench: accept 2 samples, assert clear together with in_valid -> ch_idx=0 and that sample dropped; a new 4-sample vector then packs correctly from slot 0.
REQ-035 Bench: rst=1 in HOLD and again after 3 accepts -> outputs match REQ-028 the next cycle; also run CH=32 full vector for a ch_idx wrap check.

Source files
------------

// File: rtl/bias_relu_pack.sv
// Packs per-channel dot-product results into a CH-wide activation vector:
// bias add, arithmetic shift, ReLU with saturation, then FILL/HOLD handoff.
module bias_relu_pack #(
   parameter int DATA_LEN = 16,
   parameter int CH       = 32,
   parameter int CW       = $clog2(CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic [DATA_LEN-1:0]    in_data,
   output logic                   in_ready,
   input  logic [CH*DATA_LEN-1:0] bias,
   input  logic [3:0]             shift,
   output logic [CW-1:0]          ch_idx,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CH*DATA_LEN-1:0] out_data
);

   typedef enum logic {S_FILL, S_HOLD} state_t;

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [CW-1:0]         r_ch_idx;
   logic [DATA_LEN-1:0]   r_slot [CH];

   logic [DATA_LEN-1:0]   w_bias_arr [CH];
   logic [DATA_LEN-1:0]   w_bias;
   logic signed [DATA_LEN:0] w_sum;
   logic signed [DATA_LEN:0] w_shifted;
   logic [DATA_LEN-1:0]   w_act;
   logic                  w_accept;
   logic                  w_last;

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_chan
         assign w_bias_arr[gi]                     = bias[gi*DATA_LEN +: DATA_LEN];
         assign out_data[gi*DATA_LEN +: DATA_LEN] = r_slot[gi];
      end
   endgenerate

   assign w_bias = w_bias_arr[r_ch_idx];

   // One extra bit keeps the sum exact so the shift can bring it back in range.
   assign w_sum     = $signed({in_data[DATA_LEN-1], in_data}) + $signed({w_bias[DATA_LEN-1], w_bias});
   assign w_shifted = w_sum >>> shift;

   always_comb begin
      w_act = w_shifted[DATA_LEN-1:0];
      if (w_shifted[DATA_LEN])
         w_act = '0;
      else if (w_shifted[DATA_LEN-1])
         w_act = {1'b0, {(DATA_LEN-1){1'b1}}};
   end

   assign w_accept = in_valid && r_in_ready && (r_state == S_FILL) && !clear;
   assign w_last   = (r_ch_idx == CW'(CH-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_FILL;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_ch_idx    <= '0;
      end else if (clear) begin
         r_state     <= S_FILL;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_ch_idx    <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_ch_idx    <= '0;
                     r_state     <= S_HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_ch_idx <= r_ch_idx + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_state     <= S_FILL;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_FILL;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Slots are only rewritten on accept; stale values persist until overwritten.
   always_ff @(posedge clk) begin
      for (int k = 0; k < CH; k++) begin
         if (rst)
            r_slot[k] <= '0;
         else if (w_accept && (r_ch_idx == CW'(k)))
            r_slot[k] <= w_act;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign ch_idx    = r_ch_idx;

endmodule

// File: tb/tb_bias_relu_pack.sv
// Directed bench for bias_relu_pack: CH=4 functional vectors plus a CH=32 wrap check.
module tb_bias_relu_pack;

   logic        clk;
   logic        rst, clear, in_valid, out_ready;
   logic [15:0] in_data;
   logic        in_ready, out_valid;
   logic [63:0] bias;
   logic [3:0]  shift;
   logic [1:0]  ch_idx;
   logic [63:0] out_data;

   logic         rst2, clear2, in_valid2, out_ready2;
   logic [15:0]  in_data2;
   logic         in_ready2, out_valid2;
   logic [511:0] bias2;
   logic [3:0]   shift2;
   logic [4:0]   ch_idx2;
   logic [511:0] out_data2;

   int n_checks = 0;
   int n_err    = 0;
   logic [63:0] exp_vec;

   bias_relu_pack #(.DATA_LEN(16), .CH(4)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .bias(bias), .shift(shift), .ch_idx(ch_idx),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   bias_relu_pack #(.DATA_LEN(16), .CH(32)) dut32 (
      .clk(clk), .rst(rst2), .clear(clear2), .in_valid(in_valid2), .in_data(in_data2),
      .in_ready(in_ready2), .bias(bias2), .shift(shift2), .ch_idx(ch_idx2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic logic [15:0] slot(input logic [63:0] v, input int k);
      return v[k*16 +: 16];
   endfunction

   // Present one sample for one edge; caller drops in_valid when done.
   task automatic push(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      $display("push ch=%0d data=%0d", ch_idx, $signed(d));
      @(negedge clk);
   endtask

   task automatic release_vec();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      $display("handoff out_valid=%0d in_ready=%0d", out_valid, in_ready);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_ch_idx"},    64'(ch_idx),    64'd0);
      check({tag, "_out_data"},  out_data,       64'd0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; bias = '0; shift = '0;
      rst2 = 1'b1; clear2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
      in_data2 = '0; bias2 = '0; shift2 = '0;
      @(negedge clk);
      @(negedge clk);
      check_reset("reset");
      rst = 1'b0; rst2 = 1'b0;

      // Plain pass-through, back-to-back
      for (int k = 0; k < 4; k++) begin
         check("fill_ch_idx", 64'(ch_idx), 64'(k));
         check("fill_in_ready", 64'(in_ready), 64'd1);
         push(16'(10 * (k + 1)));
      end
      in_valid = 1'b0;
      check("pass_out_valid", 64'(out_valid), 64'd1);
      check("pass_in_ready", 64'(in_ready), 64'd0);
      exp_vec = {16'd40, 16'd30, 16'd20, 16'd10};
      check("pass_data", out_data, exp_vec);
      @(negedge clk);
      check("pass_hold_in_ready", 64'(in_ready), 64'd0);
      release_vec();
      check("pass_rel_valid", 64'(out_valid), 64'd0);
      check("pass_rel_ready", 64'(in_ready), 64'd1);

      // Bias, shift, ReLU, 17-bit sum
      bias  = {16'd32767, 16'd0, 16'hFFCE, 16'd0};
      shift = 4'd2;
      push(16'd100); push(16'd20); push(16'hFFFC); push(16'd32767);
      in_valid = 1'b0;
      exp_vec = {16'd16383, 16'd0, 16'd0, 16'd25};
      check("shift_relu_data", out_data, exp_vec);
      release_vec();

      // Saturation at both ends
      shift = 4'd0;
      bias  = {4{16'd32000}};
      for (int k = 0; k < 4; k++) push(16'd32000);
      in_valid = 1'b0;
      check("sat_hi_slot0", 64'(slot(out_data, 0)), 64'd32767);
      check("sat_hi_slot3", 64'(slot(out_data, 3)), 64'd32767);
      release_vec();
      bias = {4{16'h8000}};
      for (int k = 0; k < 4; k++) push(16'h8000);
      in_valid = 1'b0;
      check("sat_lo_data", out_data, 64'd0);
      release_vec();

      // HOLD backpressure with in_valid asserted
      bias = '0;
      push(16'd1); push(16'd2); push(16'd3); push(16'd4);
      exp_vec = {16'd4, 16'd3, 16'd2, 16'd1};
      in_valid = 1'b1;
      in_data  = 16'd99;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_ready", 64'(in_ready), 64'd0);
      end
      check("hold_data", out_data, exp_vec);
      check("hold_ch_idx", 64'(ch_idx), 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("handoff_valid", 64'(out_valid), 64'd0);
      check("handoff_ready", 64'(in_ready), 64'd1);
      check("handoff_no_accept", 64'(ch_idx), 64'd0);
      check("handoff_slot0", 64'(slot(out_data, 0)), 64'd1);

      // Clear mid-vector beats in_valid
      push(16'd5); push(16'd6);
      check("pre_clear_idx", 64'(ch_idx), 64'd2);
      clear = 1'b1; in_valid = 1'b1; in_data = 16'd77;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      check("clear_idx", 64'(ch_idx), 64'd0);
      check("clear_drop_slot2", 64'(slot(out_data, 2)), 64'd3);
      push(16'd11); push(16'd12); push(16'd13); push(16'd14);
      in_valid = 1'b0;
      exp_vec = {16'd14, 16'd13, 16'd12, 16'd11};
      check("after_clear_valid", 64'(out_valid), 64'd1);
      check("after_clear_data", out_data, exp_vec);
      // Clear in HOLD drops the vector
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_hold_valid", 64'(out_valid), 64'd0);
      check("clear_hold_ready", 64'(in_ready), 64'd1);

      // Reset in HOLD, overriding clear and handshakes
      push(16'd1); push(16'd2); push(16'd3); push(16'd4);
      rst = 1'b1; clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check_reset("rst_hold");
      // Reset mid-vector
      push(16'd7); push(16'd8); push(16'd9);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset("rst_mid");
      push(16'd21);
      in_valid = 1'b0;
      check("post_rst_idx", 64'(ch_idx), 64'd1);
      check("post_rst_slot0", 64'(slot(out_data, 0)), 64'd21);

      // CH=32 full vector and index wrap
      for (int k = 0; k < 32; k++) begin
         check("ch32_idx", 64'(ch_idx2), 64'(k));
         in_valid2 = 1'b1;
         in_data2  = 16'(k + 1);
         $display("push32 ch=%0d data=%0d", ch_idx2, k + 1);
         @(negedge clk);
      end
      in_valid2 = 1'b0;
      check("ch32_valid", 64'(out_valid2), 64'd1);
      check("ch32_wrap", 64'(ch_idx2), 64'd0);
      check("ch32_slot0", 64'(out_data2[0 +: 16]), 64'd1);
      check("ch32_slot17", 64'(out_data2[17*16 +: 16]), 64'd18);
      check("ch32_slot31", 64'(out_data2[31*16 +: 16]), 64'd32);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
